// File: rtl/adpll_pkg.sv
// -----------------------------------------------------------------------------
// adpll_pkg
// Definitions shared by the ADPLL blocks:
//   - FSM state encoding of the counter phase detector
//   - ERROR_WIDTH-based saturation limit (symmetric, +/-MAX)
//   - saturating-increment helper
// No ports (package).
// -----------------------------------------------------------------------------
package adpll_pkg;

    localparam logic [1:0] ST_WARMUP   = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_REF_LEAD = 2'd2;
    localparam logic [1:0] ST_FB_LEAD  = 2'd3;

    localparam int unsigned ERROR_WIDTH_DEFAULT = 8;

    // Largest magnitude of a signed error word; -2^(w-1) is deliberately unused
    // so the range stays symmetric.
    function automatic logic [31:0] err_max(input int unsigned width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

    localparam logic [31:0] ERR_MAX_DEFAULT = err_max(ERROR_WIDTH_DEFAULT);

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
        return (v >= lim) ? lim : v + 32'd1;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
// Multi-flop synchroniser followed by a rise detector (prev/curr).
//   gen_clk_i : system clock
//   reset_i   : async active-high reset
//   i_async   : asynchronous input
//   i_mask    : suppresses the rise pulse (warm-up after reset)
//   o_rise    : one-cycle pulse on a synchronised 0->1 transition
// -----------------------------------------------------------------------------
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic gen_clk_i,
    input  logic reset_i,
    input  logic i_async,
    input  logic i_mask,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            // prev keeps tracking while masked so a level that is already high
            // when the mask lifts is not seen as an edge
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev & ~i_mask;

endmodule

// File: rtl/counter_phase_detector.sv
// -----------------------------------------------------------------------------
// counter_phase_detector
// Measures the rising-edge separation of ref and fb (in gen_clk_i cycles) and
// emits a saturated signed error for the ADPLL loop filter, plus lock status.
//   gen_clk_i     : system clock
//   reset_i       : async active-high reset
//   ref_i, fb_i   : reference / DCO feedback clocks (asynchronous)
//   error_o       : signed error, +ve = ref leads fb; 0 outside valid cycles
//   error_valid_o : one-cycle strobe per measurement
//   locked_o      : LOCK_COUNT consecutive measurements with |error|<=LOCK_THRESH
// -----------------------------------------------------------------------------
module counter_phase_detector
    import adpll_pkg::*;
#(
    parameter int ERROR_WIDTH = 8,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_THRESH = 2,
    parameter int LOCK_COUNT  = 16
) (
    input  logic                          gen_clk_i,
    input  logic                          reset_i,
    input  logic                          ref_i,
    input  logic                          fb_i,
    output logic signed [ERROR_WIDTH-1:0] error_o,
    output logic                          error_valid_o,
    output logic                          locked_o
);

    localparam int               CW  = ERROR_WIDTH - 1;
    localparam int               WW  = $clog2(SYNC_STAGES + 2);
    localparam int               LW  = $clog2(LOCK_COUNT + 1);
    localparam logic [CW-1:0]    MAX = CW'(err_max(ERROR_WIDTH));

    logic [1:0]    r_state,  w_state_nxt;
    logic [WW-1:0] r_wcnt,   w_wcnt_nxt;
    logic [CW-1:0] r_count,  w_count_nxt;
    logic [LW-1:0] r_lock,   w_lock_nxt;
    logic          r_valid;
    logic          r_locked;
    logic signed [ERROR_WIDTH-1:0] r_err;

    logic [1:0]    w_in, w_rise;
    logic          w_mask, w_ref, w_fb;
    logic          w_emit, w_neg, w_inlock;
    logic [CW-1:0] w_mag;
    logic signed [ERROR_WIDTH-1:0] w_mag_s, w_err;

    // lane 0 = ref, lane 1 = fb
    assign w_in   = {fb_i, ref_i};
    assign w_mask = (r_state == ST_WARMUP);

    for (genvar g = 0; g < 2; g++) begin : g_lane
        edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .gen_clk_i (gen_clk_i),
            .reset_i   (reset_i),
            .i_async   (w_in[g]),
            .i_mask    (w_mask),
            .o_rise    (w_rise[g])
        );
    end

    assign w_ref = w_rise[0];
    assign w_fb  = w_rise[1];

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_count_nxt = r_count;
        w_emit      = 1'b0;
        w_neg       = 1'b0;
        w_mag       = '0;
        case (r_state)
            ST_WARMUP: begin
                // SYNC_STAGES+1 masked cycles: synchroniser and prev both settle
                if (r_wcnt == WW'(SYNC_STAGES)) w_state_nxt = ST_IDLE;
                else                            w_wcnt_nxt  = r_wcnt + WW'(1);
            end
            ST_IDLE: begin
                if (w_ref && w_fb) begin
                    w_emit = 1'b1;
                end else if (w_ref) begin
                    w_state_nxt = ST_REF_LEAD;
                    w_count_nxt = CW'(1);
                end else if (w_fb) begin
                    w_state_nxt = ST_FB_LEAD;
                    w_count_nxt = CW'(1);
                end
            end
            ST_REF_LEAD: begin
                if (w_fb) begin
                    w_emit = 1'b1;
                    w_mag  = r_count;
                    // coincident ref edge opens the next window immediately
                    if (w_ref) w_count_nxt = CW'(1);
                    else       w_state_nxt = ST_IDLE;
                end else if (w_ref) begin
                    w_emit      = 1'b1;
                    w_mag       = MAX;
                    w_count_nxt = CW'(1);
                end else begin
                    w_count_nxt = CW'(sat_inc(32'(r_count), 32'(MAX)));
                end
            end
            ST_FB_LEAD: begin
                w_neg = 1'b1;
                if (w_ref) begin
                    w_emit = 1'b1;
                    w_mag  = r_count;
                    if (w_fb) w_count_nxt = CW'(1);
                    else      w_state_nxt = ST_IDLE;
                end else if (w_fb) begin
                    w_emit      = 1'b1;
                    w_mag       = MAX;
                    w_count_nxt = CW'(1);
                end else begin
                    w_count_nxt = CW'(sat_inc(32'(r_count), 32'(MAX)));
                end
            end
            default: w_state_nxt = ST_WARMUP;
        endcase
    end

    assign w_mag_s  = $signed({1'b0, w_mag});
    assign w_err    = w_neg ? -w_mag_s : w_mag_s;
    assign w_inlock = (32'(w_mag) <= 32'(LOCK_THRESH));

    always_comb begin
        w_lock_nxt = r_lock;
        if (w_emit)
            w_lock_nxt = w_inlock ? LW'(sat_inc(32'(r_lock), 32'(LOCK_COUNT))) : '0;
    end

    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state  <= ST_WARMUP;
            r_wcnt   <= '0;
            r_count  <= '0;
            r_lock   <= '0;
            r_valid  <= 1'b0;
            r_err    <= '0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wcnt   <= w_wcnt_nxt;
            r_count  <= w_count_nxt;
            r_lock   <= w_lock_nxt;
            r_valid  <= w_emit;
            r_err    <= w_emit ? w_err : '0;
            // registered from the next count so lock follows its valid strobe
            r_locked <= (w_lock_nxt == LW'(LOCK_COUNT));
        end
    end

    assign error_o       = r_err;
    assign error_valid_o = r_valid;
    assign locked_o      = r_locked;

endmodule

// File: tb/tb_counter_phase_detector.sv
module tb_counter_phase_detector;

    localparam int EW   = 8;
    localparam int SS   = 2;
    localparam int LT   = 2;
    localparam int LC   = 16;
    localparam int MAXV = (1 << (EW - 1)) - 1;

    logic gen_clk_i = 1'b0;
    logic reset_i, ref_i, fb_i;
    logic signed [EW-1:0] error_o;
    logic error_valid_o, locked_o;

    counter_phase_detector #(
        .ERROR_WIDTH(EW), .SYNC_STAGES(SS), .LOCK_THRESH(LT), .LOCK_COUNT(LC)
    ) dut (
        .gen_clk_i     (gen_clk_i),
        .reset_i       (reset_i),
        .ref_i         (ref_i),
        .fb_i          (fb_i),
        .error_o       (error_o),
        .error_valid_o (error_valid_o),
        .locked_o      (locked_o)
    );

    always #5 gen_clk_i = ~gen_clk_i;

    int total = 0;
    int bad   = 0;

    // monitor: collect every measurement, watch the idle-cycle rules
    int vq[$];
    int lq[$];
    int idle_bad    = 0;
    int lock_glitch = 0;
    logic prev_lock = 1'b0;

    always @(negedge gen_clk_i) begin
        if (error_valid_o === 1'b1) begin
            vq.push_back(int'(error_o));
            lq.push_back(int'(locked_o));
        end else begin
            if (error_o !== '0) idle_bad++;
            if (reset_i === 1'b0 && locked_o !== prev_lock) lock_glitch++;
        end
        prev_lock = locked_o;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // single-cycle-high pulses on the given cycle indices (-1 = unused)
    task automatic pulses(input int ra, input int rb, input int fa, input int fb);
        int len;
        len = ra;
        if (rb > len) len = rb;
        if (fa > len) len = fa;
        if (fb > len) len = fb;
        for (int c = 0; c <= len; c++) begin
            @(negedge gen_clk_i);
            ref_i = (c == ra) || (c == rb);
            fb_i  = (c == fa) || (c == fb);
        end
        @(negedge gen_clk_i);
        ref_i = 1'b0;
        fb_i  = 1'b0;
        repeat (10) @(negedge gen_clk_i);
    endtask

    task automatic expect_vals(input string name, input int n, input int e0, input int e1);
        chk({name, "_count"}, vq.size(), n);
        if (vq.size() > 0) chk({name, "_v0"}, vq[0], e0);
        if (n > 1 && vq.size() > 1) chk({name, "_v1"}, vq[1], e1);
        vq.delete();
        lq.delete();
    endtask

    task automatic do_reset();
        @(negedge gen_clk_i);
        reset_i = 1'b1;
        ref_i   = 1'b0;
        fb_i    = 1'b0;
        repeat (3) @(negedge gen_clk_i);
        reset_i = 1'b0;
        repeat (6) @(negedge gen_clk_i);
        vq.delete();
        lq.delete();
    endtask

    typedef struct {
        int rd;
        int fd;
        int exp;
    } vec_t;

    vec_t tbl[11];

    // reference model: timestamps of the open window, error = distance clipped
    int exp_q[$];
    int expl_q[$];
    int m_open, m_t0, m_streak;

    task automatic m_emit(input int e);
        int a;
        a = (e < 0) ? -e : e;
        exp_q.push_back(e);
        m_streak = (a <= LT) ? m_streak + 1 : 0;
        expl_q.push_back((m_streak >= LC) ? 1 : 0);
    endtask

    task automatic m_step(input int c, input bit r, input bit f);
        int d;
        d = (c - m_t0 > MAXV) ? MAXV : c - m_t0;
        if (m_open == 0) begin
            if (r && f)  m_emit(0);
            else if (r) begin m_open = 1; m_t0 = c; end
            else if (f) begin m_open = 2; m_t0 = c; end
        end else if (m_open == 1) begin
            if (f) begin
                m_emit(d);
                if (r) m_t0 = c; else m_open = 0;
            end else if (r) begin
                m_emit(MAXV);
                m_t0 = c;
            end
        end else begin
            if (r) begin
                m_emit(-d);
                if (f) m_t0 = c; else m_open = 0;
            end else if (f) begin
                m_emit(-MAXV);
                m_t0 = c;
            end
        end
    endtask

    initial begin
        tbl[0]  = '{0, 5, 5};
        tbl[1]  = '{3, 0, -3};
        tbl[2]  = '{0, 0, 0};
        tbl[3]  = '{0, 1, 1};
        tbl[4]  = '{1, 0, -1};
        tbl[5]  = '{0, 126, 126};
        tbl[6]  = '{0, 127, 127};
        tbl[7]  = '{0, 128, MAXV};
        tbl[8]  = '{0, 200, MAXV};
        tbl[9]  = '{10, 0, -10};
        tbl[10] = '{0, 2, 2};

        reset_i = 1'b1;
        ref_i   = 1'b0;
        fb_i    = 1'b0;
        repeat (2) @(negedge gen_clk_i);
        chk("rst_error", int'(error_o), 0);
        chk("rst_valid", int'(error_valid_o), 0);
        chk("rst_locked", int'(locked_o), 0);
        reset_i = 1'b0;
        repeat (6) @(negedge gen_clk_i);
        chk("warmup_quiet0", vq.size(), 0);

        foreach (tbl[i]) begin
            pulses(tbl[i].rd, -1, tbl[i].fd, -1);
            expect_vals($sformatf("vec%0d", i), 1, tbl[i].exp, 0);
        end

        // missed fb edge: second ref gives +MAX, window restarts at 1
        pulses(0, 10, 13, -1);
        expect_vals("ref_twice", 2, MAXV, 3);
        // coincident edges while ref leads: +count, next window opened by ref
        pulses(0, 7, 7, 9);
        expect_vals("ref_both", 2, 7, 2);
        // mirror: missed ref edge
        pulses(5, -1, 0, 3);
        expect_vals("fb_twice", 2, -MAXV, -2);

        // lock acquisition and loss
        do_reset();
        for (int i = 0; i < LC; i++) begin
            if (i % 2 == 0) pulses(0, -1, 1, -1);
            else            pulses(1, -1, 0, -1);
        end
        chk("lock_meas", vq.size(), LC);
        if (lq.size() >= LC) begin
            chk("lock_first", lq[0], 0);
            chk("lock_15th", lq[LC-2], 0);
            chk("lock_16th", lq[LC-1], 1);
        end
        vq.delete();
        lq.delete();
        pulses(0, -1, 10, -1);
        chk("unlock_count", vq.size(), 1);
        if (vq.size() > 0) begin
            chk("unlock_val", vq[0], 10);
            chk("unlock_lock", lq[0], 0);
        end
        vq.delete();
        lq.delete();

        // reset mid-window, release with both inputs high
        @(negedge gen_clk_i); ref_i = 1'b1;
        @(negedge gen_clk_i); ref_i = 1'b0;
        repeat (3) @(negedge gen_clk_i);
        reset_i = 1'b1;
        ref_i   = 1'b1;
        fb_i    = 1'b1;
        repeat (2) @(negedge gen_clk_i);
        chk("midrst_valid", vq.size(), 0);
        reset_i = 1'b0;
        repeat (12) @(negedge gen_clk_i);
        chk("warmup_quiet", vq.size(), 0);
        ref_i = 1'b0;
        fb_i  = 1'b0;
        repeat (4) @(negedge gen_clk_i);
        pulses(0, -1, 4, -1);
        expect_vals("post_reset", 1, 4, 0);

        // randomized phase against the model
        do_reset();
        m_open = 0; m_t0 = 0; m_streak = 0;
        begin
            int  c;
            bit  rv, fv, r, f;
            int  dv;
            c = 0; rv = 0; fv = 0;
            for (int blk = 0; blk < 6; blk++) begin
                dv = (blk % 3 == 0) ? 4 : ((blk % 3 == 1) ? 16 : 150);
                for (int k = 0; k < 500; k++) begin
                    @(negedge gen_clk_i);
                    r = !rv && ($urandom_range(dv - 1) == 0);
                    f = !fv && ($urandom_range(dv - 1) == 0);
                    rv = r; fv = f;
                    ref_i = r;
                    fb_i  = f;
                    m_step(c, r, f);
                    c++;
                end
            end
            @(negedge gen_clk_i);
            ref_i = 1'b0;
            fb_i  = 1'b0;
            repeat (10) @(negedge gen_clk_i);
        end
        chk("rand_count", vq.size(), exp_q.size());
        for (int i = 0; i < vq.size() && i < exp_q.size(); i++) begin
            chk($sformatf("rand_err%0d", i), vq[i], exp_q[i]);
            chk($sformatf("rand_lock%0d", i), lq[i], expl_q[i]);
        end

        chk("idle_zero", idle_bad, 0);
        chk("lock_hold", lock_glitch, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
